// File: rtl/bmc_sched_pkg.sv
// bmc_sched_pkg: shared FSM state type and default sizing for the BMC scheduler.
package bmc_sched_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int NGRP_DEF = 8;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/bmc_grp_cnt.sv
// bmc_grp_cnt: group index counter with terminal-count flag at NGRP-1.
module bmc_grp_cnt
  import bmc_sched_pkg::*;
#(
  parameter int NGRP = NGRP_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  output logic [$clog2(NGRP)-1:0] grp,
  output logic                    tc
);
  assign tc = grp == ($clog2(NGRP))'(NGRP - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) grp <= '0;
    else grp <= clr ? '0 : inc ? grp + 1'b1 : grp;
endmodule

// File: rtl/bmc_sched.sv
// bmc_sched: sequences one received symbol pair across NGRP BMC state groups.
// Define BMC_SCHED_PREFETCH_EN to accept the next pair during the final beat.
module bmc_sched
  import bmc_sched_pkg::*;
#(
  parameter int NGRP  = NGRP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_pair,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_pair,
  output logic [$clog2(NGRP)-1:0] out_grp,
  output logic                    out_last,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        sym_cnt
);
  state_t state;
  logic up, last_q, tc, acc, cons;
  assign out_valid = state == BUSY;
  assign cons = out_valid & out_ready;
  assign acc = in_valid & in_ready;
  assign out_last = out_valid & last_q & tc;
`ifdef BMC_SCHED_PREFETCH_EN
  assign in_ready = up & (state == IDLE | (cons & tc));
`else
  assign in_ready = up & (state == IDLE);
`endif
  // counter returns to 0 after the final beat so an idle block never shows tc
  bmc_grp_cnt #(.NGRP(NGRP)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (acc | (cons & tc)),
    .inc  (cons),
    .grp  (out_grp),
    .tc   (tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      up         <= 1'b0;
      out_pair   <= '0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
      sym_cnt    <= '0;
    end else begin
      up         <= 1'b1;
      frame_done <= cons & out_last;
      if (cons & tc) sym_cnt <= last_q ? '0 : &sym_cnt ? sym_cnt : sym_cnt + 1'b1;
      if (acc) begin
        out_pair <= in_pair;
        last_q   <= in_last;
        state    <= BUSY;
      end else if (cons & tc) state <= IDLE;
    end
endmodule

// File: tb/tb_bmc_sched.sv
// tb_bmc_sched: directed table plus hand sequences for bmc_sched (NGRP=8).
module tb_bmc_sched;
`ifdef BMC_SCHED_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [1:0] in_pair = 2'b00;
  logic in_ready, out_valid, out_last, frame_done;
  logic [1:0] out_pair;
  logic [2:0] out_grp;
  logic [15:0] sym_cnt;
  logic u2_in_ready, u2_out_valid, u2_out_last, u2_frame_done;
  logic [1:0] u2_out_pair;
  logic [2:0] u2_out_grp;
  logic [1:0] u2_sym_cnt;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bmc_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pair(in_pair), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_pair(out_pair), .out_grp(out_grp), .out_last(out_last),
    .frame_done(frame_done), .sym_cnt(sym_cnt)
  );
  bmc_sched #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u2_in_ready),
    .in_pair(in_pair), .in_last(in_last), .out_valid(u2_out_valid), .out_ready(out_ready),
    .out_pair(u2_out_pair), .out_grp(u2_out_grp), .out_last(u2_out_last),
    .frame_done(u2_frame_done), .sym_cnt(u2_sym_cnt)
  );

  typedef struct {
    logic iv;
    logic [1:0] ip;
    logic il;
    logic ordy;
    logic [24:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [24:0] pk(logic irdy, logic ov, logic [2:0] g, logic l, logic fd,
                                     logic [15:0] c, logic [1:0] p);
    return {irdy, ov, g, l, fd, c, p};
  endfunction

  function automatic void add(logic iv, logic [1:0] ip, logic il, logic ordy, logic [24:0] e);
    vec_t v;
    v.iv = iv; v.ip = ip; v.il = il; v.ordy = ordy; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // From posedge+1: accept one pair, then run beats until grp==stop (returns at that
  // negedge) or, with stop<0, until the last beat is consumed (returns at posedge+1).
  task automatic sym(input logic [1:0] p, input logic l, input int stop);
    int n = 0;
    in_valid = 1'b1; in_pair = p; in_last = l; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 20) begin chk("ready_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_pair = 2'b00; in_last = 1'b0;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      chk("sym_grp", out_grp, g);
      if (g == stop) return;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pr [3];
    logic [15:0] ecnt [3];
    int idx, beats, gaps, k, acc_c, last_c;
    logic prev_tc, acc;
    pr[0] = 2'b01; pr[1] = 2'b10; pr[2] = 2'b11;
    ecnt[0] = 16'd1; ecnt[1] = 16'd2; ecnt[2] = 16'd0;

    // single last symbol straight out of reset
    add(0, 2'b00, 0, 1, pk(0, 0, 0, 0, 0, 0, 2'b00));
    add(1, 2'b01, 1, 1, pk(1, 0, 0, 0, 0, 0, 2'b00));
    for (int g = 0; g < 8; g++)
      add(0, 2'b00, 0, 1, pk(PF && g == 7, 1, 3'(g), g == 7, 0, 0, 2'b01));
    add(0, 2'b00, 0, 1, pk(1, 0, 0, 0, 1, 0, 2'b01));
    add(0, 2'b00, 0, 1, pk(1, 0, 0, 0, 0, 0, 2'b01));

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", pk(in_ready, out_valid, out_grp, out_last, frame_done, sym_cnt, out_pair), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_pair = tbl[i].ip; in_last = tbl[i].il; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl_row%0d", i),
          pk(in_ready, out_valid, out_grp, out_last, frame_done, sym_cnt, out_pair), tbl[i].exp);
      @(posedge clk); #1;
    end

    // three-symbol frame, back-to-back offer
    idx = 0; beats = 0; gaps = 0; k = 0; acc_c = -1; last_c = -1; prev_tc = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = idx < 3; in_pair = idx < 3 ? pr[idx] : 2'b00; in_last = idx == 2; out_ready = 1'b1;
      @(negedge clk);
      if (prev_tc) begin
        chk("frm_cnt", sym_cnt, ecnt[k]);
        chk("frm_cnt_w2", u2_sym_cnt, ecnt[k]);
        chk("frm_done", frame_done, k == 2);
        k++;
      end
      if (out_valid) begin
        chk("frm_grp", out_grp, beats % 8);
        chk("frm_pair", out_pair, pr[beats / 8]);
        chk("frm_last", out_last, beats == 23);
        beats++;
        last_c = c;
      end else if (beats > 0 && beats < 24) gaps++;
      prev_tc = out_valid && out_grp == 3'd7;
      acc = in_valid && in_ready;
      if (acc && acc_c < 0) acc_c = c;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("frm_syms", k, 3);
    chk("frm_beats", beats, 24);
    chk("frm_gaps", gaps, PF ? 0 : 2);
    chk("frm_span", last_c - acc_c + 1, PF ? 25 : 27);

    // backpressure at grp 3, with a competing pair offered while busy
    sym(2'b10, 1'b1, 3);
    out_ready = 1'b0; in_valid = 1'b1; in_pair = 2'b01; in_last = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_state", {out_valid, in_ready, out_grp, out_pair, out_last}, {1'b1, 1'b0, 3'd3, 2'b10, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0; in_pair = 2'b00;
    for (int g = 3; g < 8; g++) begin
      @(negedge clk);
      chk("stall_resume", {out_grp, out_pair, out_last}, {3'(g), 2'b10, g == 7});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_done", {out_valid, frame_done, sym_cnt}, {1'b0, 1'b1, 16'd0});
    @(posedge clk); #1;

    // reset in the middle of a last symbol
    sym(2'b00, 1'b0, -1);
    chk("pre_rst_cnt", sym_cnt, 1);
    sym(2'b11, 1'b1, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", pk(in_ready, out_valid, out_grp, out_last, frame_done, sym_cnt, out_pair), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_rdy_low", {in_ready, frame_done, out_valid}, 3'b000);
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_after", {in_ready, frame_done, out_valid, sym_cnt}, {3'b100, 16'd0});
      @(posedge clk); #1;
    end

    // saturation of the 2-bit counter against the 16-bit one
    for (int s = 1; s <= 5; s++) begin
      sym(2'b01, 1'b0, -1);
      chk("sat_cnt16", sym_cnt, s);
      chk("sat_cnt2", u2_sym_cnt, s > 3 ? 3 : s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
